// File: rtl/fetch_stack_core.sv
// -----------------------------------------------------------------------------
// fetch_stack_core
//
// Sequencing datapath of the control unit. It holds the 16-bit instruction
// register (IR), the 9-bit program counter (PC) and a hardware call stack.
// Each stack entry is a return address plus the ALU flags saved with it. The
// micro-sequencer drives the one-hot control strobes every cycle.
//
// Optional feature: when the macro STACK_STATUS_EN is defined, the status
// ports stack_full, stack_empty and stack_err are present. stack_err is a
// sticky error flag.
//
// Strobe semantics: a strobe is sampled on the rising edge of clk. Its effect
// is visible one cycle later. No strobe needs a handshake.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   ir_load      capture ir_in into IR
//   ir_in[15:0]  instruction word from program memory
//   ir_out[15:0] current IR contents
//   pc_load      load PC from the selected source
//                (the stack top for a return instruction, else IR[10:2])
//   pc_inc       increment PC; pc_load wins when both are high
//   pc_en_out    gates the pc_out port only
//   pc_out[8:0]  PC when pc_en_out=1, else 0
//   push_en      push {PC, flags_in}
//   pop_en       pop the top entry
//   flags_in[3:0] flags to save on push
//   stk_pc[8:0]  top-of-stack return address (0 when empty)
//   stk_flags[3:0] top-of-stack saved flags (0 when empty)
//   stack_full / stack_empty / stack_err   (STACK_STATUS_EN only)
// -----------------------------------------------------------------------------
module fetch_stack_core #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_load,
    input  logic [15:0] ir_in,
    output logic [15:0] ir_out,
    input  logic        pc_load,
    input  logic        pc_inc,
    input  logic        pc_en_out,
    output logic [8:0]  pc_out,
    input  logic        push_en,
    input  logic        pop_en,
    input  logic [3:0]  flags_in,
    output logic [8:0]  stk_pc,
    output logic [3:0]  stk_flags
`ifdef STACK_STATUS_EN
    ,
    output logic        stack_full,
    output logic        stack_empty,
    output logic        stack_err
`endif
);

    localparam int AW = $clog2(STACK_DEPTH);
    // sp counts entries, so it needs one more bit than the array index.
    localparam logic [AW:0] SP_FULL = (AW+1)'(STACK_DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [4:0]  OP_RET  = 5'b10101;

    logic [15:0]   ir_q;
    logic [8:0]    pc_q, pc_d;
    logic [AW:0]   sp_q, sp_d;
    logic [8:0]    mem_pc    [STACK_DEPTH];
    logic [3:0]    mem_flags [STACK_DEPTH];

    logic          empty_w, full_w;
    logic [AW:0]   sp_m1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          do_push, do_repl, do_pop, wr_en;
    logic [8:0]    pc_src;

    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == SP_FULL);
    assign sp_m1   = sp_q - SP_ONE;
    assign top_idx = sp_m1[AW-1:0];

    // Push and pop together replace the top entry in place. On an empty
    // stack there is nothing to replace, so this case becomes a plain push.
    assign do_repl = push_en & pop_en & ~empty_w;
    assign do_push = push_en & ((~pop_en & ~full_w) | (pop_en & empty_w));
    assign do_pop  = pop_en & ~push_en & ~empty_w;
    assign wr_en   = do_push | do_repl;
    assign wr_idx  = do_repl ? top_idx : sp_q[AW-1:0];

    // The top of stack is read combinationally. A pop and a PC load from the
    // stack in the same cycle therefore use the entry being popped.
    assign stk_pc    = empty_w ? 9'h000 : mem_pc[top_idx];
    assign stk_flags = empty_w ? 4'h0   : mem_flags[top_idx];

    // The source mux reads the current IR. An IR load in the same cycle as a
    // PC load does not affect the loaded value.
    assign pc_src = (ir_q[15:11] == OP_RET) ? stk_pc : ir_q[10:2];

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_src;
        end else if (pc_inc) begin
            pc_d = pc_q + 9'd1;
        end
    end

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_ONE;
        end else if (do_pop) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= 16'h0000;
            pc_q <= 9'h000;
            sp_q <= '0;
        end else begin
            if (ir_load) begin
                ir_q <= ir_in;
            end
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: entries at or above sp are never observed.
    // A push stores the PC value from before this cycle's update.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_pc[wr_idx]    <= pc_q;
            mem_flags[wr_idx] <= flags_in;
        end
    end

    assign ir_out = ir_q;
    assign pc_out = pc_en_out ? pc_q : 9'h000;

`ifdef STACK_STATUS_EN
    logic stack_err_q;

    // Sticky error flag. It is set by a lone push while full or a lone pop
    // while empty. A push+pop pair is never an error. Only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err_q <= 1'b0;
        end else if ((push_en & ~pop_en & full_w) | (pop_en & ~push_en & empty_w)) begin
            stack_err_q <= 1'b1;
        end
    end

    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign stack_err   = stack_err_q;
`endif

endmodule

// File: tb/tb_fetch_stack_core.sv
module tb_fetch_stack_core;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ir_load;
  logic [15:0] ir_in;
  logic [15:0] ir_out;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_en_out;
  logic [8:0]  pc_out;
  logic        push_en;
  logic        pop_en;
  logic [3:0]  flags_in;
  logic [8:0]  stk_pc;
  logic [3:0]  stk_flags;
`ifdef STACK_STATUS_EN
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;
`endif

  fetch_stack_core #(.STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_load   (ir_load),
    .ir_in     (ir_in),
    .ir_out    (ir_out),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .pc_en_out (pc_en_out),
    .pc_out    (pc_out),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .flags_in  (flags_in),
    .stk_pc    (stk_pc),
    .stk_flags (stk_flags)
`ifdef STACK_STATUS_EN
    ,
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_ir;
  logic [8:0]  m_pc;
  logic [12:0] m_stk[$];   // {pc, flags}; back of queue is top of stack
  bit          m_err;

  function automatic logic [12:0] m_top();
    if (m_stk.size() == 0) return 13'h0;
    return m_stk[m_stk.size()-1];
  endfunction

  task automatic model_step();
    logic [12:0] top;
    logic [8:0]  src;
    logic [12:0] ent;
    if (rst) begin
      m_ir = 16'h0;
      m_pc = 9'h0;
      m_stk.delete();
      m_err = 0;
      return;
    end
    top = m_top();
    ent = {m_pc, flags_in};
    src = (m_ir[15:11] == 5'b10101) ? top[12:4] : m_ir[10:2];
    if (push_en && pop_en) begin
      if (m_stk.size() == 0) m_stk.push_back(ent);
      else m_stk[m_stk.size()-1] = ent;
    end else if (push_en) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(ent);
      else m_err = 1;
    end else if (pop_en) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_err = 1;
    end
    if (pc_load) m_pc = src;
    else if (pc_inc) m_pc = m_pc + 9'd1;
    if (ir_load) m_ir = ir_in;
  endtask

  // Compare every observable output with the model. Called with clk low.
  task automatic compare_all();
    logic [12:0] top;
    top = m_top();
    check("ir_out", 32'(ir_out), 32'(m_ir));
    check("pc_out", 32'(pc_out), pc_en_out ? 32'(m_pc) : 32'h0);
    check("stk_pc", 32'(stk_pc), 32'(top[12:4]));
    check("stk_flags", 32'(stk_flags), 32'(top[3:0]));
`ifdef STACK_STATUS_EN
    check("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    check("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
    check("stack_err", 32'(stack_err), 32'(m_err));
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge. The task applies the strobes, compares the
  // outputs for the current state and advances the model. It then waits for
  // the rising edge and returns at the next falling edge.
  task automatic drive(input logic r, input logic irl, input logic [15:0] iri,
                       input logic pl, input logic pi, input logic en,
                       input logic pu, input logic po, input logic [3:0] fl);
    rst = r; ir_load = irl; ir_in = iri; pc_load = pl; pc_inc = pi;
    pc_en_out = en; push_en = pu; pop_en = po; flags_in = fl;
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load IR with an instruction and then load the PC from it.
  task automatic jump(input logic [15:0] insn);
    drive(0, 1, insn, 0, 0, 1, 0, 0, 4'h0);
    drive(0, 0, 16'h0, 1, 0, 1, 0, 0, 4'h0);
  endtask

  initial begin
    m_ir = 16'h0; m_pc = 9'h0; m_err = 0;
    rst = 1; ir_load = 0; ir_in = 0; pc_load = 0; pc_inc = 0;
    pc_en_out = 0; push_en = 0; pop_en = 0; flags_in = 0;
    @(negedge clk);
    // Reset: no comparison yet, because the state before reset is unknown.
    model_step();
    @(posedge clk);
    @(negedge clk);

    check("rst_ir", 32'(ir_out), 32'h0);
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_stk_pc", 32'(stk_pc), 32'h0);
    check("rst_stk_flags", 32'(stk_flags), 32'h0);
`ifdef STACK_STATUS_EN
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_full", 32'(stack_full), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
`endif

    // Increment three times, then gate the output.
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 16'h0, 0, 1, 1, 0, 0, 4'h0);
      check("pc_inc_seq", 32'(pc_out), 32'(i));
    end
    pc_en_out = 0; #1;
    check("pc_gated", 32'(pc_out), 32'h0);

    // Jump, then load and increment together.
    jump(16'h8028);
    check("jump_pc", 32'(pc_out), 32'h00A);
    drive(0, 0, 16'h0, 1, 1, 1, 0, 0, 4'h0);
    check("load_over_inc", 32'(pc_out), 32'h00A);

    // Wrap from 1FF to 000.
    jump(16'h07FC);
    check("pc_1ff", 32'(pc_out), 32'h1FF);
    drive(0, 0, 16'h0, 0, 1, 1, 0, 0, 4'h0);
    check("pc_wrap", 32'(pc_out), 32'h000);

    // Call and return.
    jump(16'h0014);
    check("call_pc5", 32'(pc_out), 32'h005);
    drive(0, 0, 16'h0, 0, 0, 1, 1, 0, 4'b0001);
    jump(16'h0100);
    check("call_target", 32'(pc_out), 32'h040);
    drive(0, 1, 16'hA800, 0, 0, 1, 0, 0, 4'h0);
    check("ret_flags_live", 32'(stk_flags), 32'h1);
    check("ret_pc_live", 32'(stk_pc), 32'h005);
    drive(0, 0, 16'h0, 1, 0, 1, 0, 1, 4'h0);
    check("ret_pc", 32'(pc_out), 32'h005);
    check("ret_empty_pc", 32'(stk_pc), 32'h0);
`ifdef STACK_STATUS_EN
    check("ret_empty", 32'(stack_empty), 32'h1);
`endif

    // Overflow and underflow. Push i stores PC=i because pc_inc runs alongside.
    drive(1, 0, 16'h0, 0, 0, 1, 0, 0, 4'h0);
    for (int i = 0; i <= DEPTH; i++)
      drive(0, 0, 16'h0, 0, 1, 1, 1, 0, 4'(i));
    check("ovf_top_pc", 32'(stk_pc), 32'(DEPTH - 1));
    check("ovf_top_flags", 32'(stk_flags), 32'((DEPTH - 1) & 15));
`ifdef STACK_STATUS_EN
    check("ovf_full", 32'(stack_full), 32'h1);
    check("ovf_err", 32'(stack_err), 32'h1);
`endif
    for (int i = 0; i <= DEPTH; i++)
      drive(0, 0, 16'h0, 0, 0, 1, 0, 1, 4'h0);
    check("udf_stk_pc", 32'(stk_pc), 32'h0);
`ifdef STACK_STATUS_EN
    check("udf_empty", 32'(stack_empty), 32'h1);
`endif

    // Push and pop together replace the top entry.
    drive(1, 0, 16'h0, 0, 0, 1, 0, 0, 4'h0);
    jump(16'h000C);
    drive(0, 0, 16'h0, 0, 0, 1, 1, 0, 4'h2);
    jump(16'h001C);
    drive(0, 0, 16'h0, 0, 0, 1, 1, 1, 4'h4);
    check("repl_pc", 32'(stk_pc), 32'h007);
    check("repl_flags", 32'(stk_flags), 32'h4);
    drive(0, 0, 16'h0, 0, 0, 1, 0, 1, 4'h0);
    check("repl_depth1", 32'(stk_pc), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] insn;
      insn = {($urandom_range(0, 2) == 0) ? 5'b10101 : 5'($urandom), 11'($urandom)};
      drive(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 2) == 0), insn,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
            4'($urandom));
    end
    #1;
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
